mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Responder end of the cache/control protocol: services dcache (dREN/dWEN/daddr/dstore) and icache (iREN/iaddr) requests from CPUS cores against a single-ported RAM.
- Returns dwait/iwait/dload/iload.
- Arbitrates round-robin across cores; dcache has priority over icache within a core.
- Holds a dcache grant across a two-word block transfer so fills, writebacks and flush bursts are not interleaved.

Parameters:
- CPUS, 2, number of cores (cache pairs) served.
- BURST, 2, maximum completed dcache word accesses per grant before forced re-arbitration.

Ports:
- CLK  in  1  clock.
- nRST  in  1  asynchronous active-low reset.
- dREN  in  CPUS  dcache read request, per core.
- dWEN  in  CPUS  dcache write request, per core.
- daddr  in  32*CPUS  dcache word address, core i at [32i+31:32i].
- dstore  in  32*CPUS  dcache write data.
- iREN  in  CPUS  icache read request.
- iaddr  in  32*CPUS  icache word address.
- dwait  out  CPUS  1 = dcache access not complete this cycle.
- iwait  out  CPUS  1 = icache access not complete this cycle.
- dload  out  32*CPUS  read data to dcache.
- iload  out  32*CPUS  read data to icache.
- ramREN  out  1  RAM read enable.
- ramWEN  out  1  RAM write enable.
- ramaddr  out  32  RAM address.
- ramstore  out  32  RAM write data.
- ramload  in  32  RAM read data.
- ramstate  in  2  0 FREE, 1 BUSY, 2 ACCESS (data valid / write taken this cycle), 3 ERROR.
- ramerr  out  1  sticky: ramstate==ERROR seen while serving.

Behaviour:
- Reset: state=ARB, owner=0, otype=D, rr=0, count=0, ramerr=0. All dwait/iwait=1; ramREN=ramWEN=0; ramaddr=ramstore=0.
- dload/iload for every core = ramload (broadcast). Consumers sample only when their wait=0.
- Request of core c: D if dREN[c]|dWEN[c], else I if iREN[c].
- ARB state:
  - Scan cores rr, rr+1, ... mod CPUS; first core with any request wins.
  - Register owner=c and otype (D over I); count=0; next state SERVE.
  - No requester: stay in ARB.
  - Arbitration costs exactly 1 cycle; no RAM enables are driven in ARB.
- SERVE, otype D:
  - ramWEN=dWEN[owner]; ramREN=dREN[owner]&~dWEN[owner] (write wins if both set).
  - ramaddr=daddr[owner]; ramstore=dstore[owner].
  - dwait[owner]=~(ramstate==ACCESS).
  - On ACCESS, count++.
  - Release to ARB (rr=owner+1 mod CPUS, count=0) when:
    - dREN|dWEN of owner is 0 at a cycle start, or
    - an ACCESS makes count==BURST.
  - Read/write type may change inside a grant (writeback word then fill); follow the live enables.
- SERVE, otype I:
  - ramREN=iREN[owner]; ramaddr=iaddr[owner]; iwait[owner]=~(ramstate==ACCESS).
  - Release after the first ACCESS, or when iREN drops.
- All non-owner wait outputs are 1. The owner's other-type wait is also 1.
- ramstate FREE/BUSY: wait stays 1 and the grant is held.
- ramstate ERROR: treated as not-ACCESS (wait stays 1, grant held) and sets ramerr. ramerr clears only on reset.
- Owner drops request in the same cycle as ACCESS: the access completes (wait=0); release next cycle.
- Reset mid-SERVE: enables drop to 0 asynchronously; the in-flight RAM access is abandoned.
- CPUS=1: rr is always 0; behaviour otherwise identical.

Test Plan:
- Single dcache read: core0 dREN=1, daddr=0x100; RAM gives ACCESS on the 3rd SERVE cycle with ramload=0xDEADBEEF -> ramREN=1 and ramaddr=0x100 from cycle 1; dwait[0]=0 only on that cycle; dload[0]=0xDEADBEEF.
- Block fill hold: core0 dREN on 0x200 then 0x204 (RAMLOAD) while core1 iREN=1 -> both core0 words serviced back-to-back with no core1 access between; core1 granted after count hits 2; iwait[1]=0 only on its ACCESS.
- Round-robin fairness: both cores hold dREN continuously, RAM always ACCESS -> grants alternate 0,0,1,1,0,0... with a 1-cycle ARB gap between each pair.
- Writeback then fill: core0 dWEN 0x300/0x304 with dstore 0x11/0x22 -> ramWEN=1 and ramstore=0x11 then 0x22; release after 2 ACCESS; the next dREN from core0 requires a new ARB cycle.
- Priority within a core: core0 dREN=1 and iREN=1 simultaneously -> D granted first; iwait[0]=1 until the I grant.
- ERROR and reset: ramstate=3 during SERVE -> ramerr=1, dwait stays 1. Assert nRST=0 mid-SERVE -> ramREN=0 and ramerr=0 immediately; after release, state is ARB.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Round-robin responder between per-core dcache/icache requesters
//            and one single-ported RAM. A dcache grant is held for up to
//            BURST completed words so block transfers stay contiguous.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
  parameter int CPUS  = 2,
  parameter int BURST = 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic [CPUS-1:0]      dREN,
  input  logic [CPUS-1:0]      dWEN,
  input  logic [32*CPUS-1:0]   daddr,
  input  logic [32*CPUS-1:0]   dstore,
  input  logic [CPUS-1:0]      iREN,
  input  logic [32*CPUS-1:0]   iaddr,
  output logic [CPUS-1:0]      dwait,
  output logic [CPUS-1:0]      iwait,
  output logic [32*CPUS-1:0]   dload,
  output logic [32*CPUS-1:0]   iload,
  output logic                 ramREN,
  output logic                 ramWEN,
  output logic [31:0]          ramaddr,
  output logic [31:0]          ramstore,
  input  logic [31:0]          ramload,
  input  logic [1:0]           ramstate,
  output logic                 ramerr
);

  localparam int IDXW = (CPUS > 1) ? $clog2(CPUS) : 1;
  localparam int CNTW = (BURST > 1) ? $clog2(BURST + 1) : 1;

  localparam logic [1:0]      RS_ACCESS = 2'd2;
  localparam logic [1:0]      RS_ERROR  = 2'd3;
  localparam logic [CNTW-1:0] C_BURST   = CNTW'(BURST);

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    SERVE = 1'b1
  } state_t;

  typedef enum logic [0:0] {
    OT_D = 1'b0,
    OT_I = 1'b1
  } otype_t;

  state_t            state_q, state_d;
  otype_t            otype_q, otype_d;
  logic [IDXW-1:0]   owner_q, owner_d;
  logic [IDXW-1:0]   rr_q, rr_d;
  logic [CNTW-1:0]   count_q, count_d;
  logic              ramerr_q, ramerr_d;

  logic [CPUS-1:0]   w_dreq;
  logic [CPUS-1:0]   w_req;
  logic              w_access;
  logic              w_own_dren;
  logic              w_own_dwen;
  logic              w_own_iren;
  logic [31:0]       w_own_daddr;
  logic [31:0]       w_own_dstore;
  logic [31:0]       w_own_iaddr;
  logic [IDXW-1:0]   w_next_rr;
  logic              w_arb_found;
  logic [IDXW-1:0]   w_arb_core;

  // Read data is broadcast; each consumer samples only when its wait is low.
  generate
    for (genvar gi = 0; gi < CPUS; gi++) begin : g_bcast
      assign dload[32*gi +: 32] = ramload;
      assign iload[32*gi +: 32] = ramload;
    end
  endgenerate

  assign w_dreq   = dREN | dWEN;
  assign w_req    = w_dreq | iREN;
  assign w_access = (ramstate == RS_ACCESS);

  assign w_own_dren   = dREN[owner_q];
  assign w_own_dwen   = dWEN[owner_q];
  assign w_own_iren   = iREN[owner_q];
  assign w_own_daddr  = daddr[32*owner_q +: 32];
  assign w_own_dstore = dstore[32*owner_q +: 32];
  assign w_own_iaddr  = iaddr[32*owner_q +: 32];

  // Pointer to the core after the current owner, wrapping at CPUS.
  assign w_next_rr = ((int'(owner_q) + 1) >= CPUS) ? '0 : (owner_q + 1'b1);

  // Round-robin scan starting at rr: first core with any request wins.
  always_comb begin
    int idx;
    idx         = 0;
    w_arb_found = 1'b0;
    w_arb_core  = '0;
    for (int i = 0; i < CPUS; i++) begin
      idx = (int'(rr_q) + i) % CPUS;
      if (!w_arb_found && w_req[idx]) begin
        w_arb_found = 1'b1;
        w_arb_core  = IDXW'(idx);
      end
    end
  end

  // RAM-side and cache-side outputs follow the owner's live request signals.
  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    dwait    = '1;
    iwait    = '1;
    if (state_q == SERVE) begin
      if (otype_q == OT_D) begin
        ramWEN         = w_own_dwen;
        ramREN         = w_own_dren & ~w_own_dwen;
        ramaddr        = w_own_daddr;
        ramstore       = w_own_dstore;
        dwait[owner_q] = ~w_access;
      end else begin
        ramREN         = w_own_iren;
        ramaddr        = w_own_iaddr;
        iwait[owner_q] = ~w_access;
      end
    end
  end

  // Next-state: grant in ARB, hold or release in SERVE, sticky error flag.
  always_comb begin
    state_d  = state_q;
    otype_d  = otype_q;
    owner_d  = owner_q;
    rr_d     = rr_q;
    count_d  = count_q;
    ramerr_d = ramerr_q;

    case (state_q)
      ARB: begin
        if (w_arb_found) begin
          state_d = SERVE;
          owner_d = w_arb_core;
          otype_d = w_dreq[w_arb_core] ? OT_D : OT_I;
          count_d = '0;
        end
      end
      SERVE: begin
        if (ramstate == RS_ERROR) begin
          ramerr_d = 1'b1;
        end
        if (otype_q == OT_D) begin
          if (!(w_own_dren | w_own_dwen)) begin
            state_d = ARB;
            rr_d    = w_next_rr;
            count_d = '0;
          end else if (w_access) begin
            if ((count_q + 1'b1) == C_BURST) begin
              state_d = ARB;
              rr_d    = w_next_rr;
              count_d = '0;
            end else begin
              count_d = count_q + 1'b1;
            end
          end
        end else begin
          if (!w_own_iren || w_access) begin
            state_d = ARB;
            rr_d    = w_next_rr;
            count_d = '0;
          end
        end
      end
      default: begin
        state_d = ARB;
      end
    endcase
  end

  // State register; reset abandons any in-flight access immediately.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= ARB;
      otype_q  <= OT_D;
      owner_q  <= '0;
      rr_q     <= '0;
      count_q  <= '0;
      ramerr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      otype_q  <= otype_d;
      owner_q  <= owner_d;
      rr_q     <= rr_d;
      count_q  <= count_d;
      ramerr_q <= ramerr_d;
    end
  end

  assign ramerr = ramerr_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Directed scenarios plus randomized traffic for mem_arbiter,
//            checked every cycle against a grant-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
  localparam int CPUS  = 2;
  localparam int BURST = 2;

  logic                CLK = 1'b0;
  logic                nRST;
  logic [CPUS-1:0]     dREN, dWEN, iREN;
  logic [32*CPUS-1:0]  daddr, dstore, iaddr;
  logic [CPUS-1:0]     dwait, iwait;
  logic [32*CPUS-1:0]  dload, iload;
  logic                ramREN, ramWEN, ramerr;
  logic [31:0]         ramaddr, ramstore, ramload;
  logic [1:0]          ramstate;

  int tests = 0;
  int fails = 0;

  // Reference model: one outstanding grant (or none) plus a fairness pointer.
  bit m_busy;
  int m_core;
  bit m_isd;
  int m_words;
  int m_ptr;
  bit m_err;

  mem_arbiter #(.CPUS(CPUS), .BURST(BURST)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .iREN(iREN), .iaddr(iaddr),
    .dwait(dwait), .iwait(iwait), .dload(dload), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate), .ramerr(ramerr)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy  = 0;
    m_core  = 0;
    m_isd   = 0;
    m_words = 0;
    m_ptr   = 0;
    m_err   = 0;
  endtask

  task automatic model_release();
    m_busy = 0;
    m_ptr  = (m_core + 1) % CPUS;
  endtask

  // Called just after a negedge with inputs driven: check outputs, advance
  // the model across the coming posedge, return at the next negedge.
  task automatic step();
    bit              acc, e_ren, e_wen, dreq;
    logic [31:0]     e_addr, e_store;
    logic [CPUS-1:0] e_dw, e_iw;
    int              c;
    #1;
    acc     = (ramstate == 2'd2);
    e_ren   = 0;
    e_wen   = 0;
    e_addr  = 0;
    e_store = 0;
    e_dw    = '1;
    e_iw    = '1;
    c       = m_core;
    if (m_busy) begin
      if (m_isd) begin
        e_wen     = dWEN[c];
        e_ren     = dREN[c] && !dWEN[c];
        e_addr    = daddr[32*c +: 32];
        e_store   = dstore[32*c +: 32];
        e_dw[c]   = !acc;
      end else begin
        e_ren     = iREN[c];
        e_addr    = iaddr[32*c +: 32];
        e_iw[c]   = !acc;
      end
    end
    check("dwait", 32'(dwait), 32'(e_dw));
    check("iwait", 32'(iwait), 32'(e_iw));
    check("ramREN", 32'(ramREN), 32'(e_ren));
    check("ramWEN", 32'(ramWEN), 32'(e_wen));
    check("ramaddr", ramaddr, e_addr);
    check("ramstore", ramstore, e_store);
    check("ramerr", 32'(ramerr), 32'(m_err));
    for (int k = 0; k < CPUS; k++) begin
      check("dload", dload[32*k +: 32], ramload);
      check("iload", iload[32*k +: 32], ramload);
    end
    // Advance the model by one cycle.
    if (m_busy && ramstate == 2'd3) m_err = 1;
    if (!m_busy) begin
      for (int i = 0; i < CPUS; i++) begin
        int idx;
        idx = (m_ptr + i) % CPUS;
        if (!m_busy && (dREN[idx] || dWEN[idx] || iREN[idx])) begin
          m_busy  = 1;
          m_core  = idx;
          m_isd   = dREN[idx] || dWEN[idx];
          m_words = 0;
        end
      end
    end else if (m_isd) begin
      dreq = dREN[c] || dWEN[c];
      if (!dreq) model_release();
      else if (acc) begin
        m_words++;
        if (m_words == BURST) model_release();
      end
    end else if (!iREN[c] || acc) begin
      model_release();
    end
    @(negedge CLK);
  endtask

  task automatic clear_inputs();
    dREN = '0; dWEN = '0; iREN = '0;
    daddr = '0; dstore = '0; iaddr = '0;
    ramstate = 2'd0; ramload = '0;
  endtask

  task automatic idle(input int n);
    clear_inputs();
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    nRST = 1'b0;
    clear_inputs();
    model_reset();
    #1;
    check("rst_dwait", 32'(dwait), 32'(2'b11));
    check("rst_iwait", 32'(iwait), 32'(2'b11));
    check("rst_ramREN", 32'(ramREN), 32'd0);
    check("rst_ramWEN", 32'(ramWEN), 32'd0);
    check("rst_ramaddr", ramaddr, 32'd0);
    check("rst_ramerr", 32'(ramerr), 32'd0);
    @(negedge CLK);
    @(negedge CLK);
    nRST = 1'b1;

    // Single dcache read with ACCESS on the third serve cycle.
    dREN = 2'b01; daddr[31:0] = 32'h100;
    step();
    #1 check("t1_ramaddr", ramaddr, 32'h100);
    check("t1_ramREN", 32'(ramREN), 32'd1);
    step();
    ramstate = 2'd1;
    step();
    ramstate = 2'd2; ramload = 32'hDEADBEEF;
    #1 check("t1_dwait", 32'(dwait[0]), 32'd0);
    check("t1_dload", dload[31:0], 32'hDEADBEEF);
    step();
    idle(3);

    // Block fill on core0 contending with core1 icache.
    dREN = 2'b01; iREN = 2'b10; ramstate = 2'd2;
    daddr[31:0] = 32'h200; iaddr[63:32] = 32'h4000;
    for (int i = 0; i < 8; i++) begin
      if (i == 2) daddr[31:0] = 32'h204;
      step();
    end
    idle(2);

    // Writeback of two words, then a new request needs a fresh ARB cycle.
    dWEN = 2'b01; ramstate = 2'd2;
    daddr[31:0] = 32'h300; dstore[31:0] = 32'h11;
    step();
    #1 check("wb_ramWEN", 32'(ramWEN), 32'd1);
    check("wb_store0", ramstore, 32'h11);
    step();
    daddr[31:0] = 32'h304; dstore[31:0] = 32'h22;
    #1 check("wb_store1", ramstore, 32'h22);
    step();
    dWEN = 2'b00; dREN = 2'b01;
    #1 check("wb_arb_gap", 32'(ramREN | ramWEN), 32'd0);
    step();
    step();
    idle(2);

    // Dcache beats icache within one core.
    dREN = 2'b01; iREN = 2'b01; ramstate = 2'd2;
    step();
    #1 check("pri_iwait", 32'(iwait[0]), 32'd1);
    check("pri_dwait", 32'(dwait[0]), 32'd0);
    step();
    step();
    dREN = 2'b00;
    step();
    #1 check("pri_igrant", 32'(iwait[0]), 32'd0);
    step();
    idle(2);

    // Round-robin with both cores streaming.
    dREN = 2'b11; ramstate = 2'd2;
    for (int i = 0; i < 12; i++) step();
    idle(2);

    // ERROR sets sticky ramerr; reset clears it asynchronously.
    dREN = 2'b01; ramstate = 2'd3;
    step();
    step();
    #1 check("err_ramerr", 32'(ramerr), 32'd1);
    check("err_dwait", 32'(dwait[0]), 32'd1);
    step();
    #1 nRST = 1'b0;
    #1 check("arst_ramREN", 32'(ramREN), 32'd0);
    check("arst_ramerr", 32'(ramerr), 32'd0);
    check("arst_dwait", 32'(dwait), 32'(2'b11));
    model_reset();
    @(negedge CLK);
    nRST = 1'b1;
    idle(2);

    // Randomized traffic with sticky requests and varied RAM latency.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      for (int k = 0; k < CPUS; k++) begin
        if ($urandom_range(3) == 0) begin
          dREN[k] = ($urandom_range(2) == 0);
          dWEN[k] = ($urandom_range(3) == 0);
          iREN[k] = ($urandom_range(1) == 0);
        end
        daddr[32*k +: 32]  = $urandom;
        dstore[32*k +: 32] = $urandom;
        iaddr[32*k +: 32]  = $urandom;
      end
      ramload = $urandom;
      case ($urandom_range(5))
        0:       ramstate = 2'd0;
        1:       ramstate = 2'd1;
        default: ramstate = 2'd2;
      endcase
      if (cyc > 1300 && $urandom_range(15) == 0) ramstate = 2'd3;
      step();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
